pll_reconf_ctrl: RTL and testbench

Sequencer that reprograms the system PLL through its reconfiguration management port whenever the selected video standard changes (NTSC 42.954545 MHz / PAL 48 MHz). It sits in `emu` on the 50 MHz management clock, between the status bits from `hps_io` and the `pll_cfg` instance. It holds the core in reset from the first register write until the PLL has relocked and settled.

---
 rtl/pll_reconf_pkg.sv | 48 ++++
 rtl/pll_reconf_rom.sv | 44 ++++
 rtl/pll_reconf_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pll_reconf_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reconf_pkg.sv
// Shared types and register tables for the PLL reconfiguration sequencer.
package pll_reconf_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_MODE,
    S_W_N,
    S_W_M,
    S_W_C0,
    S_W_FRAC,
    S_W_START,
    S_WAIT_DONE,
    S_WAIT_LOCK,
    S_SETTLE
  } state_e;

  localparam int CNT_W = 21;

  localparam logic [5:0] ADDR_MODE  = 6'd0;
  localparam logic [5:0] ADDR_START = 6'd2;
  localparam logic [5:0] ADDR_N     = 6'd3;
  localparam logic [5:0] ADDR_M     = 6'd4;
  localparam logic [5:0] ADDR_C0    = 6'd5;
  localparam logic [5:0] ADDR_MFRAC = 6'd7;

  // N and M are shared; only C0 and the fractional M differ between standards.
  localparam logic [31:0] N_NTSC     = 32'h0001_0000;
  localparam logic [31:0] N_PAL      = 32'h0001_0000;
  localparam logic [31:0] M_NTSC     = 32'h0000_0404;
  localparam logic [31:0] M_PAL      = 32'h0000_0404;
  localparam logic [31:0] C0_NTSC    = 32'h0000_0505;
  localparam logic [31:0] C0_PAL     = 32'h0002_0504;
  localparam logic [31:0] MFRAC_NTSC = 32'h9745_BF27;
  localparam logic [31:0] MFRAC_PAL  = 32'hA3D7_09E8;

  function automatic state_e next_write_state(input state_e s);
    case (s)
      S_W_MODE: return S_W_N;
      S_W_N:    return S_W_M;
      S_W_M:    return S_W_C0;
      S_W_C0:   return S_W_FRAC;
      S_W_FRAC: return S_W_START;
      S_W_START: return S_WAIT_DONE;
      default:  return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/pll_reconf_rom.sv
// Register table: maps the current write state and latched standard to
// the reconfiguration address/data pair.
module pll_reconf_rom
  import pll_reconf_pkg::*;
(
  input  state_e      state_i,
  input  logic        target_i,
  output logic [5:0]  addr_o,
  output logic [31:0] data_o
);

  always_comb begin
    addr_o = ADDR_MODE;
    data_o = '0;
    case (state_i)
      S_W_MODE: begin
        addr_o = ADDR_MODE;
        data_o = '0;
      end
      S_W_N: begin
        addr_o = ADDR_N;
        data_o = target_i ? N_PAL : N_NTSC;
      end
      S_W_M: begin
        addr_o = ADDR_M;
        data_o = target_i ? M_PAL : M_NTSC;
      end
      S_W_C0: begin
        addr_o = ADDR_C0;
        data_o = target_i ? C0_PAL : C0_NTSC;
      end
      S_W_FRAC: begin
        addr_o = ADDR_MFRAC;
        data_o = target_i ? MFRAC_PAL : MFRAC_NTSC;
      end
      S_W_START: begin
        addr_o = ADDR_START;
        data_o = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pll_reconf_ctrl.sv
// Reprograms the video PLL on an NTSC/PAL change and holds the core in reset
// until relock + settle. Define PLL_RECONF_BOOT_EN to program once at boot.
module pll_reconf_ctrl
  import pll_reconf_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned LOCK_TIMEOUT  = 1048576
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        pal,
  input  logic        pll_locked,
  input  logic        mgmt_waitrequest,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        core_reset,
  output logic        busy,
  output logic        pal_applied,
  output logic        lock_err
);

  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_e             state_q, state_d;
  logic               target_q, target_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               write_q, write_d;
  logic [5:0]         addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic               core_reset_q, core_reset_d;
  logic               busy_q, busy_d;
  logic               applied_q, applied_d;
  logic               err_q, err_d;
  logic               pal_meta_q, pal_s_q, lock_meta_q, lock_s_q;
  logic               start_req;
  logic [5:0]         rom_addr;
  logic [31:0]        rom_data;
`ifdef PLL_RECONF_BOOT_EN
  logic               boot_q, boot_d;
`endif

  pll_reconf_rom u_rom (
    .state_i  (state_q),
    .target_i (target_q),
    .addr_o   (rom_addr),
    .data_o   (rom_data)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef PLL_RECONF_BOOT_EN
  assign start_req = boot_q || (pal_s_q != applied_q);
`else
  assign start_req = (pal_s_q != applied_q);
`endif

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    cnt_d        = cnt_q;
    write_d      = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    core_reset_d = core_reset_q;
    busy_d       = busy_q;
    applied_d    = applied_q;
    err_d        = err_q;
`ifdef PLL_RECONF_BOOT_EN
    boot_d       = boot_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          target_d     = pal_s_q;
          busy_d       = 1'b1;
          core_reset_d = 1'b1;
          err_d        = 1'b0;
          state_d      = S_W_MODE;
`ifdef PLL_RECONF_BOOT_EN
          boot_d       = 1'b0;
`endif
        end
      end
      S_W_MODE, S_W_N, S_W_M, S_W_C0, S_W_FRAC, S_W_START: begin
        if (!mgmt_waitrequest) begin
          write_d = 1'b1;
          addr_d  = rom_addr;
          data_d  = rom_data;
          state_d = next_write_state(state_q);
        end
      end
      S_WAIT_DONE: begin
        if (!mgmt_waitrequest) begin
          cnt_d   = '0;
          state_d = S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        // Lock wins over a timeout that expires on the same cycle.
        if (lock_s_q) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else if (cnt_q == LOCK_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          applied_d    = target_q;
          core_reset_d = 1'b0;
          busy_d       = 1'b0;
          cnt_d        = '0;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      target_q     <= 1'b0;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      core_reset_q <= 1'b0;
      busy_q       <= 1'b0;
      applied_q    <= 1'b0;
      err_q        <= 1'b0;
      pal_meta_q   <= 1'b0;
      pal_s_q      <= 1'b0;
      lock_meta_q  <= 1'b0;
      lock_s_q     <= 1'b0;
`ifdef PLL_RECONF_BOOT_EN
      boot_q       <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
      applied_q    <= applied_d;
      err_q        <= err_d;
      pal_meta_q   <= pal;
      pal_s_q      <= pal_meta_q;
      lock_meta_q  <= pll_locked;
      lock_s_q     <= lock_meta_q;
`ifdef PLL_RECONF_BOOT_EN
      boot_q       <= boot_d;
`endif
    end
  end

  assign mgmt_write     = write_q;
  assign mgmt_address   = addr_q;
  assign mgmt_writedata = data_q;
  assign core_reset     = core_reset_q;
  assign busy           = busy_q;
  assign pal_applied    = applied_q;
  assign lock_err       = err_q;

endmodule

// File: tb/tb_pll_reconf_ctrl.sv
// Directed bench for pll_reconf_ctrl with a transaction-level reference model
// compared on every falling clock edge.
module tb_pll_reconf_ctrl;

  localparam int SETTLE = 20;
  localparam int TMO    = 64;
  localparam int BOUND  = 3000;
`ifdef PLL_RECONF_BOOT_EN
  localparam bit BOOT = 1'b1;
`else
  localparam bit BOOT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, pal, lock, wreq;
  logic mw, cr, bz, pa, le;
  logic [5:0]  ma;
  logic [31:0] md;

  int n_assert = 0;
  int n_fail   = 0;

  pll_reconf_ctrl #(.SETTLE_CYCLES(SETTLE), .LOCK_TIMEOUT(TMO)) dut (
    .clk_sys          (clk),
    .reset            (rst),
    .pal              (pal),
    .pll_locked       (lock),
    .mgmt_waitrequest (wreq),
    .mgmt_write       (mw),
    .mgmt_address     (ma),
    .mgmt_writedata   (md),
    .core_reset       (cr),
    .busy             (bz),
    .pal_applied      (pa),
    .lock_err         (le)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a sequence is a list of six writes drained one per
  // un-stalled cycle, then a lock wait and a fixed settle period.
  logic        m_p1, m_p2, m_l1, m_l2, m_target, m_boot;
  logic [37:0] m_q[$];
  int          m_phase, m_waited, m_left;
  logic        e_w, e_cr, e_bz, e_pa, e_le;
  logic [5:0]  e_a;
  logic [31:0] e_d;

  function automatic void load_seq(input logic p);
    m_q.delete();
    m_q.push_back({6'd0, 32'h0});
    m_q.push_back({6'd3, 32'h0001_0000});
    m_q.push_back({6'd4, 32'h0000_0404});
    m_q.push_back({6'd5, p ? 32'h0002_0504 : 32'h0000_0505});
    m_q.push_back({6'd7, p ? 32'hA3D7_09E8 : 32'h9745_BF27});
    m_q.push_back({6'd2, 32'h0});
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_p1 = 0; m_p2 = 0; m_l1 = 0; m_l2 = 0; m_target = 0; m_boot = BOOT;
      m_q.delete(); m_phase = 0; m_waited = 0; m_left = 0;
      e_w = 0; e_a = 0; e_d = 0; e_cr = 0; e_bz = 0; e_pa = 0; e_le = 0;
    end else begin
      e_w = 0;
      case (m_phase)
        0: if (m_boot || (m_p2 != e_pa)) begin
             m_boot = 0; m_target = m_p2; load_seq(m_p2);
             e_cr = 1; e_bz = 1; e_le = 0; m_phase = 1;
           end
        1: if (!wreq) begin
             {e_a, e_d} = m_q.pop_front();
             e_w = 1;
             if (m_q.size() == 0) m_phase = 2;
           end
        2: if (!wreq) begin m_phase = 3; m_waited = 0; end
        3: if (m_l2) begin
             m_phase = 4; m_left = SETTLE;
           end else begin
             m_waited++;
             if (m_waited == TMO) begin e_le = 1; m_phase = 4; m_left = SETTLE; end
           end
        4: begin
             m_left--;
             if (m_left == 0) begin e_pa = m_target; e_cr = 0; e_bz = 0; m_phase = 0; end
           end
        default: ;
      endcase
      m_p2 = m_p1; m_p1 = pal;
      m_l2 = m_l1; m_l1 = lock;
    end
  end

  logic [37:0] wr_log[$];

  always @(negedge clk) begin
    chk("mgmt_write", mw, e_w);
    chk("mgmt_address", ma, e_a);
    chk("mgmt_writedata", md, e_d);
    chk("core_reset", cr, e_cr);
    chk("busy", bz, e_bz);
    chk("pal_applied", pa, e_pa);
    chk("lock_err", le, e_le);
    if (mw) wr_log.push_back({ma, md});
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_wr(input logic [5:0] a, output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!(mw && ma == a) && cyc < BOUND);
    chk("wait_write_seen", {31'd0, mw && ma == a}, 32'd1);
  endtask

  function automatic logic sel(input int w);
    case (w)
      0: return pa;
      1: return le;
      default: return bz;
    endcase
  endfunction

  task automatic wait_sig(input int w, input logic v, output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (sel(w) !== v && cyc < BOUND);
    chk("wait_signal_seen", {31'd0, sel(w)}, {31'd0, v});
  endtask

  task automatic finish_seq(input logic p);
    int c;
    wait_wr(6'd2, c);
    step(3);
    lock = 1;
    wait_sig(0, p, c);
    lock = 0;
  endtask

  task automatic chk_log(input int base, input logic p);
    logic [5:0]  a_l[6];
    logic [31:0] d_l[6];
    a_l = '{6'd0, 6'd3, 6'd4, 6'd5, 6'd7, 6'd2};
    d_l = '{32'h0, 32'h0001_0000, 32'h0000_0404,
            p ? 32'h0002_0504 : 32'h0000_0505,
            p ? 32'hA3D7_09E8 : 32'h9745_BF27, 32'h0};
    chk("log_length", (wr_log.size() >= base + 6) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (base + i < wr_log.size()) begin
        chk("log_addr", {26'd0, wr_log[base+i][37:32]}, {26'd0, a_l[i]});
        chk("log_data", wr_log[base+i][31:0], d_l[i]);
      end
    end
  endtask

  initial begin
    int c, nw, bad;
    pal = 0; lock = 0; wreq = 0; rst = 0;
    #1 rst = 1;
    step(2);
    chk("rst_write", mw, 0);  chk("rst_addr", ma, 0); chk("rst_data", md, 0);
    chk("rst_core_reset", cr, 0); chk("rst_busy", bz, 0);
    chk("rst_applied", pa, 0); chk("rst_lock_err", le, 0);
    rst = 0;

    // Boot behaviour with pal=0
    nw = 0;
    for (int i = 0; i < 1000; i++) begin @(negedge clk); if (mw) nw++; end
    chk("boot_write_count", nw, BOOT ? 32'd6 : 32'd0);

    // Basic NTSC -> PAL
    wr_log.delete();
    pal = 1;
    wait_wr(6'd0, c);
    chk("first_write_latency", c, 4);
    chk("core_reset_in_seq", cr, 1);
    wait_wr(6'd2, c);
    step(10);
    lock = 1;
    wait_sig(0, 1'b1, c);
    chk("lock_to_applied", c, 3 + SETTLE - 1 + 1);
    lock = 0;
    chk_log(0, 1'b1);

    // Waitrequest stalls, PAL -> NTSC
    wr_log.delete();
    pal = 0;
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      if (mw && wreq) bad++;
      wreq = (k % 6 != 5);
      if (k == 50) lock = 1;
      @(negedge clk);
    end
    wreq = 0;
    wait_sig(0, 1'b0, c);
    lock = 0;
    chk("write_during_wait", bad, 0);
    chk_log(0, 1'b0);

    // Mid-sequence change back
    wr_log.delete();
    pal = 1;
    wait_wr(6'd3, c);
    pal = 0;
    finish_seq(1'b1);
    finish_seq(1'b0);
    chk("midseq_log_size", wr_log.size(), 12);
    chk_log(0, 1'b1);
    chk_log(6, 1'b0);

    // Lock timeout
    pal = 1;
    wait_wr(6'd2, c);
    wait_sig(1, 1'b1, c);
    chk("timeout_cycles", c, 1 + TMO);
    wait_sig(0, 1'b1, c);
    chk("timeout_settle", c, SETTLE);
    chk("lock_err_sticky", le, 1);
    pal = 0;
    wait_sig(2, 1'b1, c);
    chk("lock_err_cleared", le, 0);
    finish_seq(1'b0);

    // Asynchronous reset in W_C0
    wr_log.delete();
    pal = 1;
    wait_wr(6'd4, c);
    #1 rst = 1;
    #1;
    chk("arst_write", mw, 0); chk("arst_addr", ma, 0); chk("arst_data", md, 0);
    chk("arst_core_reset", cr, 0); chk("arst_busy", bz, 0);
    chk("arst_applied", pa, 0); chk("arst_lock_err", le, 0);
    step(2);
    rst = 0;
    wr_log.delete();
    finish_seq(1'b1);
    if (BOOT) begin
      wait_sig(0, 1'b1, c);
      chk_log(6, 1'b1);
    end else begin
      chk_log(0, 1'b1);
    end
    chk("arst_final_applied", pa, 1);

    step(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
